// File: rtl/interrupt_controller.sv
// interrupt_controller
//
// Collects level-sensitive device interrupt requests, selects the
// highest-priority pending device (bit 0 highest), squashes fetch for a
// programmable number of non-stalled cycles, then issues a single-cycle
// acknowledge to the system register file and to the serviced device.
// Further interrupts are held off until RETI retires.
//
// Ports
//   clk        in   system clock, rising edge
//   reset      in   asynchronous, active-low; clears all state
//   irq        in   [NDEV]  level-sensitive requests, bit 0 highest priority
//   ie         in   global interrupt enable
//   pipeStall  in   pipeline cannot advance; drain count frozen
//   isReti     in   RETI retiring this cycle
//   flush      out  squash fetch while draining
//   inta       out  one-cycle acknowledge to the system register file
//   idn        out  [DBITS] winner index + 1 while inta=1, else 0
//   devAck     out  [NDEV]  one-hot, one-cycle acknowledge to the device
//   busy       out  interrupt in service
//
// State table
//   IDLE    | waiting for an enabled pending request
//   DRAIN   | flushing the pipeline, counting non-stalled cycles
//   ACK     | single acknowledge cycle (inta, idn, devAck)
//   SERVICE | handler running, waits for RETI

module interrupt_controller #(
  parameter int DBITS        = 32,
  parameter int NDEV         = 4,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NDEV-1:0]  irq,
  input  logic             ie,
  input  logic             pipeStall,
  input  logic             isReti,
  output logic             flush,
  output logic             inta,
  output logic [DBITS-1:0] idn,
  output logic [NDEV-1:0]  devAck,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DRAIN   = 2'd1,
    ACK     = 2'd2,
    SERVICE = 2'd3
  } state_t;

  state_t          state;
  logic [NDEV-1:0] pending;
  logic [3:0]      winner;
  logic [3:0]      drain_cnt;
  logic [3:0]      first_idx;
  logic [4:0]      winner_inc;

  // Lowest set index wins; scanning downward lets the lowest overwrite last.
  always_comb begin
    first_idx = '0;
    for (int i = NDEV - 1; i >= 0; i--) begin
      if (pending[i]) first_idx = 4'(i);
    end
  end

  assign winner_inc = {1'b0, winner} + 5'd1;

  // Outputs are registered alongside the state so each one reflects the
  // state being entered; nothing from an input reaches an output directly.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      pending   <= '0;
      winner    <= '0;
      drain_cnt <= '0;
      flush     <= 1'b0;
      inta      <= 1'b0;
      idn       <= '0;
      devAck    <= '0;
      busy      <= 1'b0;
    end else begin
      pending <= irq;
      // Acknowledge outputs only ever last one cycle.
      inta    <= 1'b0;
      idn     <= '0;
      devAck  <= '0;
      case (state)
        IDLE: begin
          if (ie && |pending) begin
            winner    <= first_idx;
            drain_cnt <= 4'(DRAIN_CYCLES - 1);
            flush     <= 1'b1;
            state     <= DRAIN;
          end
        end
        DRAIN: begin
          // Dropping ie abandons the drain before stall or count matter.
          if (!ie) begin
            flush <= 1'b0;
            state <= IDLE;
          end else if (!pipeStall) begin
            if (drain_cnt == 4'd0) begin
              flush  <= 1'b0;
              inta   <= 1'b1;
              idn    <= {{(DBITS-5){1'b0}}, winner_inc};
              devAck <= NDEV'(1) << winner;
              state  <= ACK;
            end else begin
              drain_cnt <= drain_cnt - 4'd1;
            end
          end
        end
        ACK: begin
          busy  <= 1'b1;
          state <= SERVICE;
        end
        SERVICE: begin
          if (isReti) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/interrupt_controller.md
# interrupt_controller

Interrupt controller that sits directly upstream of the system register file. It collects level-sensitive device interrupt requests, picks the highest-priority pending device, and drains the pipeline. It then issues a one-cycle interrupt acknowledge with the device number to the system register file and holds off further interrupts until RETI retires. It also returns a one-hot acknowledge pulse to the serviced device.

## Interface
- DBITS, 32, data width of idn (matches the system register file)
- NDEV, 4, number of device request lines (1..15)
- DRAIN_CYCLES, 3, number of non-stalled cycles of fetch squash before acknowledge (1..16)

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low; clears all state
- irq  in  NDEV  level-sensitive requests; bit 0 has highest priority
- ie  in  1  global interrupt enable (PCS bit 0 from the system register file)
- pipeStall  in  1  pipeline cannot advance this cycle; drain counter frozen
- isReti  in  1  RETI retiring this cycle
- flush  out  1  squash fetch / stop issue while draining
- inta  out  1  one-cycle interrupt acknowledge to the system register file
- idn  out  DBITS  winner index + 1, zero-extended, valid only while inta=1, else 0
- devAck  out  NDEV  one-hot, one-cycle acknowledge to the serviced device
- busy  out  1  interrupt in service (SERVICE state)

## Operation
- pending: NDEV-bit register, pending <= irq every cycle (one sync stage); cleared by reset.
- winner: 4-bit register, latched on IDLE->DRAIN as lowest set index of pending.
- drainCnt: 4-bit down-counter.
- States: IDLE, DRAIN, ACK, SERVICE; 2-bit encoded state register.
- IDLE: if ie && |pending, latch winner, load drainCnt = DRAIN_CYCLES-1, go DRAIN. Otherwise stay.
- DRAIN: flush=1.
  - If ie=0, abort to IDLE (winner discarded, no inta, no devAck).
  - Else if pipeStall=1, hold drainCnt.
  - Else if drainCnt==0, go ACK.
  - Else decrement drainCnt.
  - The ie abort has priority over stall and count.
- ACK (exactly one cycle): inta=1, idn=winner+1, devAck[winner]=1, flush=0; go SERVICE unconditionally. The winner is serviced even if its irq dropped during DRAIN.
- SERVICE: busy=1. New requests accumulate in pending but are not taken. isReti=1 goes to IDLE.
- isReti outside SERVICE is ignored.
- All outputs are Moore, decoded from registered state/winner. No combinational path from any input to any output.
- idn arithmetic: {DBITS-5 zeros, 5-bit winner+1}. Winner is never NDEV or higher.

## Timing
- Reset values (reset low, asynchronous): state=IDLE, pending=0, winner=0, drainCnt=0, flush=0, inta=0, idn=0, devAck=0, busy=0.
- Reset asserted mid-operation, including during ACK: outputs drop to reset values immediately, with no completion of the in-flight acknowledge.
- Latency with irq rising in cycle 0, ie=1, no stall:
  - pending visible in cycle 1
  - DRAIN in cycles 2..DRAIN_CYCLES+1
  - ACK in cycle DRAIN_CYCLES+2
  - SERVICE from cycle DRAIN_CYCLES+3
- With DRAIN_CYCLES=3, inta is in cycle 5.
- Each stall cycle in DRAIN adds exactly one cycle.
- flush falls in the same cycle inta rises.
- isReti in SERVICE cycle n: IDLE in n+1. If a request is still pending and ie=1, DRAIN begins in n+2.
- Simultaneous requests: lowest index wins. Others stay pending while their irq is held.

## Test plan
- Single request, no stall: irq=4'b0100 in cycle 0, ie=1, DRAIN_CYCLES=3 -> flush=1 cycles 2-4; inta=1, idn=3, devAck=4'b0100 in cycle 5 only; busy=1 from cycle 6.
- Priority and back-to-back: irq=4'b1010 held, pulse isReti in SERVICE -> first ACK idn=2, devAck=0010; after isReti, second ACK again idn=2 while bit 1 held. After dropping bit 1, the next ACK is idn=4, devAck=1000.
- Stall during drain: irq=0001, pipeStall=1 on cycles 3 and 4 -> inta in cycle 7, flush=1 cycles 2-6.
- ie drop abort: irq=0001, ie falls in cycle 3 -> flush clears in cycle 4; no inta and no devAck ever. Re-raising ie restarts DRAIN two cycles later.
- Reset mid-flight: reset low during ACK cycle -> inta, idn, devAck and flush are 0 immediately. After release with irq=0 the block stays idle indefinitely.
- Spurious RETI and masked: isReti pulses in IDLE and ie=0 with irq=1111 for 20 cycles -> no state change, all outputs 0.
